// File: rtl/trig_clock_modulator_if.sv
// Control and status bundle of the trigger-modulated clock fanout.
// The master side drives triggers and configuration; the slave side is the modulator.
interface trig_clock_modulator_if #(
  parameter int NCH = 4,
  parameter int PW  = 3
);
  logic           sma_trig;
  logic           mode;
  logic [NCH-1:0] ch_en;
  logic           ovf_clr;
  logic [NCH-1:0] trig_out;
  logic           sma_trig_monitor;
  logic           sym_strobe;
  logic [PW-1:0]  pending;
  logic           overflow;

  modport master (
    output sma_trig, mode, ch_en, ovf_clr,
    input  trig_out, sma_trig_monitor, sym_strobe, pending, overflow
  );

  modport slave (
    input  sma_trig, mode, ch_en, ovf_clr,
    output trig_out, sma_trig_monitor, sym_strobe, pending, overflow
  );
endinterface

// File: rtl/trig_clock_modulator.sv
// Trigger-modulated clock for the mPMT RJ45 fanout: osc_clk is cut into DIV-cycle
// symbols, idle symbols carry a short pulse, queued triggers a long or missing one.
module trig_clock_modulator #(
  parameter int DIV    = 4,
  parameter int LOW_W  = 1,
  parameter int HIGH_W = 3,
  parameter int NCH    = 4,
  parameter int QDEPTH = 4,
  localparam int PW    = $clog2(QDEPTH + 1)
) (
  input logic                    osc_clk,
  input logic                    rst_n,
  trig_clock_modulator_if.slave  bus
);
  localparam int PHW = (DIV > 1) ? $clog2(DIV) : 1;

  logic           s1_r, s2_r, s3_r;
  logic [PHW-1:0] ph_r;
  logic           cur_sym_r;
  logic           cur_mode_r;
  logic [NCH-1:0] ch_en_q_r;
  logic [PW-1:0]  pending_r;
  logic           overflow_r;
  logic [NCH-1:0] trig_out_r;
  logic           monitor_r;

  logic           edge_s;
  logic           boundary_s;
  logic           take_s;
  logic           drop_s;
  logic [PW-1:0]  pending_nx_s;
  logic           overflow_nx_s;
  logic           wave_s;

  assign edge_s     = s2_r & ~s3_r;
  assign boundary_s = (ph_r == PHW'(DIV - 1));
  assign take_s     = boundary_s & (pending_r != PW'(0));

  // Three-flop synchroniser on the asynchronous SMA trigger
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= bus.sma_trig;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Phase within the current symbol
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_r <= PHW'(0);
    end else if (boundary_s) begin
      ph_r <= PHW'(0);
    end else begin
      ph_r <= ph_r + PHW'(1);
    end
  end

  // Symbol type, mode and channel mask only change at a boundary, so no runt pulses
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sym_r  <= 1'b0;
      cur_mode_r <= 1'b0;
      ch_en_q_r  <= {NCH{1'b0}};
    end else if (boundary_s) begin
      cur_sym_r  <= (pending_r != PW'(0));
      cur_mode_r <= bus.mode;
      ch_en_q_r  <= bus.ch_en;
    end else begin
      cur_sym_r  <= cur_sym_r;
      cur_mode_r <= cur_mode_r;
      ch_en_q_r  <= ch_en_q_r;
    end
  end

  // Trigger queue occupancy; a simultaneous edge and consume leaves it unchanged
  always_comb begin
    pending_nx_s = pending_r;
    drop_s       = 1'b0;
    if (edge_s && !take_s) begin
      if (pending_r == PW'(QDEPTH)) begin
        drop_s = 1'b1;
      end else begin
        pending_nx_s = pending_r + PW'(1);
      end
    end else if (!edge_s && take_s) begin
      pending_nx_s = pending_r - PW'(1);
    end else begin
      pending_nx_s = pending_r;
    end
  end

  // Sticky overflow: a drop outranks a clear in the same cycle
  always_comb begin
    overflow_nx_s = overflow_r;
    if (drop_s) begin
      overflow_nx_s = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_nx_s = 1'b0;
    end else begin
      overflow_nx_s = overflow_r;
    end
  end

  // Queue and overflow state
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= PW'(0);
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_nx_s;
      overflow_r <= overflow_nx_s;
    end
  end

  // Waveform of the current symbol at the current phase
  always_comb begin
    wave_s = 1'b0;
    case (cur_mode_r)
      1'b0:    wave_s = ph_r < (cur_sym_r ? PHW'(HIGH_W) : PHW'(LOW_W));
      1'b1:    wave_s = ~cur_sym_r & (ph_r < PHW'(DIV / 2));
      default: wave_s = 1'b0;
    endcase
  end

  // Registered, per-channel gated outputs
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_out_r <= {NCH{1'b0}};
      monitor_r  <= 1'b0;
    end else begin
      trig_out_r <= {NCH{wave_s}} & ch_en_q_r;
      monitor_r  <= cur_sym_r;
    end
  end

  assign bus.trig_out         = trig_out_r;
  assign bus.sma_trig_monitor = monitor_r;
  assign bus.sym_strobe       = boundary_s;
  assign bus.pending          = pending_r;
  assign bus.overflow         = overflow_r;
endmodule

// File: tb/tb_trig_clock_modulator.sv
// Bench for trig_clock_modulator: a DIV=4 and a DIV=32 instance share stimulus and
// are compared against a symbol-table reference model built from the behaviour rules.
module tb_trig_clock_modulator;
  localparam int NCH  = 4;
  localparam int QD   = 4;
  localparam int PW   = 3;
  localparam int SYMS = 4096;

  logic osc_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic sma_trig = 1'b0;
  logic mode     = 1'b0;
  logic [NCH-1:0] ch_en = 4'hF;
  logic ovf_clr  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 osc_clk = ~osc_clk;

  trig_clock_modulator_if #(.NCH(NCH), .PW(PW)) if_a ();
  trig_clock_modulator_if #(.NCH(NCH), .PW(PW)) if_b ();

  assign if_a.sma_trig = sma_trig;
  assign if_a.mode     = mode;
  assign if_a.ch_en    = ch_en;
  assign if_a.ovf_clr  = ovf_clr;
  assign if_b.sma_trig = sma_trig;
  assign if_b.mode     = mode;
  assign if_b.ch_en    = ch_en;
  assign if_b.ovf_clr  = ovf_clr;

  trig_clock_modulator #(.DIV(4), .LOW_W(1), .HIGH_W(3), .NCH(NCH), .QDEPTH(QD)) dut_a (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .bus     (if_a)
  );

  trig_clock_modulator #(.DIV(32), .LOW_W(8), .HIGH_W(24), .NCH(NCH), .QDEPTH(QD)) dut_b (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .bus     (if_b)
  );

  logic [NCH-1:0] obs_to   [2];
  logic           obs_mon  [2];
  logic           obs_stb  [2];
  logic [PW-1:0]  obs_pend [2];
  logic           obs_ovf  [2];

  assign obs_to[0]   = if_a.trig_out;
  assign obs_to[1]   = if_b.trig_out;
  assign obs_mon[0]  = if_a.sma_trig_monitor;
  assign obs_mon[1]  = if_b.sma_trig_monitor;
  assign obs_stb[0]  = if_a.sym_strobe;
  assign obs_stb[1]  = if_b.sym_strobe;
  assign obs_pend[0] = if_a.pending;
  assign obs_pend[1] = if_b.pending;
  assign obs_ovf[0]  = if_a.overflow;
  assign obs_ovf[1]  = if_b.overflow;

  // Reference model: per-instance symbol tables indexed by symbol number since reset
  int             ecount [2];
  int             pend   [2];
  bit             ovf    [2];
  bit             sym_trig [2][SYMS];
  bit             sym_mode [2][SYMS];
  logic [NCH-1:0] sym_chen [2][SYMS];
  logic [NCH-1:0] e_to  [2];
  bit             e_mon [2];
  bit             e_stb [2];
  bit             sq [$];

  function automatic int mdiv(int d);
    return (d == 0) ? 4 : 32;
  endfunction

  function automatic int mlow(int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic int mhigh(int d);
    return (d == 0) ? 3 : 24;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ecount[d] = 0;
      pend[d] = 0;
      ovf[d] = 1'b0;
      e_to[d] = '0;
      e_mon[d] = 1'b0;
      e_stb[d] = 1'b0;
      sym_trig[d][0] = 1'b0;
      sym_mode[d][0] = 1'b0;
      sym_chen[d][0] = '0;
    end
    sq.delete();
  endtask

  task automatic model_edge(int d, bit e);
    int k, dv, ph, cs, ns;
    bit bnd, had, take, drop, w;
    k = ecount[d];
    dv = mdiv(d);
    ph = k % dv;
    cs = (k / dv) % SYMS;
    bnd = (ph == dv - 1);
    had = (pend[d] > 0);
    take = bnd && had;
    drop = 1'b0;
    if (e && !take) begin
      if (pend[d] < QD) pend[d] = pend[d] + 1;
      else drop = 1'b1;
    end else if (!e && take) begin
      pend[d] = pend[d] - 1;
    end
    if (drop) ovf[d] = 1'b1;
    else if (ovf_clr) ovf[d] = 1'b0;
    if (!sym_mode[d][cs]) w = (ph < (sym_trig[d][cs] ? mhigh(d) : mlow(d)));
    else w = !sym_trig[d][cs] && (ph < dv / 2);
    e_to[d] = w ? sym_chen[d][cs] : '0;
    e_mon[d] = sym_trig[d][cs];
    if (bnd) begin
      ns = (k / dv + 1) % SYMS;
      sym_trig[d][ns] = had;
      sym_mode[d][ns] = mode;
      sym_chen[d][ns] = ch_en;
    end
    ecount[d] = k + 1;
    e_stb[d] = ((k + 1) % dv == dv - 1);
  endtask

  // One clock: advance the model at the rising edge, return at the falling edge
  task automatic tick();
    bit e;
    @(posedge osc_clk);
    if (rst_n) begin
      e = ((sq.size() > 1) ? sq[1] : 1'b0) & ~((sq.size() > 2) ? sq[2] : 1'b0);
      for (int d = 0; d < 2; d++) model_edge(d, e);
      sq.push_front(sma_trig);
      if (sq.size() > 3) void'(sq.pop_back());
    end
    @(negedge osc_clk);
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_to[d] !== 4'h0 || obs_mon[d] !== 1'b0 || obs_stb[d] !== 1'b0 ||
          obs_pend[d] !== 3'd0 || obs_ovf[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d got to=%h mon=%b stb=%b pend=%0d ovf=%b want all 0",
                 d, obs_to[d], obs_mon[d], obs_stb[d], obs_pend[d], obs_ovf[d]);
      end
    end
    @(negedge osc_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [NCH-1:0] want;
    repeat (40) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_to[d] !== e_to[d] || obs_stb[d] !== e_stb[d]) begin
          n_bad++;
          $display("FAIL idle_model inst%0d got to=%h stb=%b want to=%h stb=%b",
                   d, obs_to[d], obs_stb[d], e_to[d], e_stb[d]);
        end
      end
      if (ecount[0] > 4) begin
        want = ((ecount[0] - 1) % 4 == 0) ? 4'hF : 4'h0;
        n_cmp++;
        if (obs_to[0] !== want || obs_stb[0] !== (ecount[0] % 4 == 3)) begin
          n_bad++;
          $display("FAIL idle_1000 cyc %0d got to=%h stb=%b want to=%h stb=%b",
                   ecount[0], obs_to[0], obs_stb[0], want, (ecount[0] % 4 == 3));
        end
      end
    end
  endtask

  task automatic test_single_trigger();
    int mon_cnt = 0;
    int hi_cnt = 0;
    sma_trig = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 8) sma_trig = 1'b0;
      tick();
      n_cmp++;
      if (obs_to[0] !== e_to[0] || obs_mon[0] !== e_mon[0] || obs_pend[0] !== 3'(pend[0])) begin
        n_bad++;
        $display("FAIL single_model got to=%h mon=%b pend=%0d want to=%h mon=%b pend=%0d",
                 obs_to[0], obs_mon[0], obs_pend[0], e_to[0], e_mon[0], pend[0]);
      end
      if (obs_mon[0]) begin
        mon_cnt++;
        if (obs_to[0] === 4'hF) hi_cnt++;
      end
    end
    n_cmp++;
    if (mon_cnt != 4 || hi_cnt != 3 || obs_pend[0] !== 3'd0) begin
      n_bad++;
      $display("FAIL single_1110 got mon_cycles=%0d high_cycles=%0d pend=%0d want 4 3 0",
               mon_cnt, hi_cnt, obs_pend[0]);
    end
  endtask

  task automatic test_mode1();
    int mon_cnt = 0;
    int bad_hi = 0;
    int guard = 0;
    mode = 1'b1;
    repeat (8) tick();
    sma_trig = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 3) sma_trig = 1'b0;
      tick();
      n_cmp++;
      if (obs_to[0] !== e_to[0] || obs_to[1] !== e_to[1]) begin
        n_bad++;
        $display("FAIL mode1_model got %h/%h want %h/%h", obs_to[0], obs_to[1], e_to[0], e_to[1]);
      end
      if (obs_mon[0]) begin
        mon_cnt++;
        if (obs_to[0] !== 4'h0) bad_hi++;
      end
    end
    n_cmp++;
    if (mon_cnt != 4 || bad_hi != 0) begin
      n_bad++;
      $display("FAIL mode1_missing got mon_cycles=%0d nonzero=%0d want 4 0", mon_cnt, bad_hi);
    end
    while (ecount[0] % 4 != 0 && guard < 8) begin
      tick();
      guard++;
    end
    mode = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs_to[0] !== 4'hF) begin
      n_bad++;
      $display("FAIL mode_midsym got %h want %h", obs_to[0], 4'hF);
    end
    repeat (12) begin
      tick();
      n_cmp++;
      if (obs_to[0] !== e_to[0] || obs_to[1] !== e_to[1]) begin
        n_bad++;
        $display("FAIL mode_switch got %h/%h want %h/%h", obs_to[0], obs_to[1], e_to[0], e_to[1]);
      end
    end
  endtask

  task automatic align_b();
    int guard = 0;
    while (pend[1] != 0 && guard < 300) begin
      tick();
      guard++;
    end
    do begin
      tick();
      guard++;
    end while (ecount[1] % 32 != 0 && guard < 400);
    n_cmp++;
    if (guard >= 400) begin
      n_bad++;
      $display("FAIL align_timeout got %0d cycles want < 400", guard);
    end
  endtask

  task automatic test_overflow();
    int max_p = 0;
    int mon_cnt = 0;
    align_b();
    repeat (6) begin
      for (int c = 0; c < 4; c++) begin
        sma_trig = (c < 2);
        tick();
        n_cmp++;
        if (obs_pend[1] !== 3'(pend[1]) || obs_ovf[1] !== ovf[1]) begin
          n_bad++;
          $display("FAIL burst_model got pend=%0d ovf=%b want pend=%0d ovf=%b",
                   obs_pend[1], obs_ovf[1], pend[1], ovf[1]);
        end
        if (int'(obs_pend[1]) > max_p) max_p = int'(obs_pend[1]);
      end
    end
    sma_trig = 1'b0;
    n_cmp++;
    if (max_p != 4 || obs_ovf[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_saturate got max_pend=%0d ovf=%b want 4 1", max_p, obs_ovf[1]);
    end
    repeat (160) begin
      tick();
      n_cmp++;
      if (obs_to[1] !== e_to[1] || obs_mon[1] !== e_mon[1]) begin
        n_bad++;
        $display("FAIL drain_model got to=%h mon=%b want to=%h mon=%b",
                 obs_to[1], obs_mon[1], e_to[1], e_mon[1]);
      end
      if (obs_mon[1]) mon_cnt++;
    end
    n_cmp++;
    if (mon_cnt != 128 || obs_pend[1] !== 3'd0) begin
      n_bad++;
      $display("FAIL drain_count got mon_cycles=%0d pend=%0d want 128 0", mon_cnt, obs_pend[1]);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++;
    if (obs_ovf[1] !== 1'b0 || obs_ovf[1] !== ovf[1]) begin
      n_bad++;
      $display("FAIL ovf_clr got %b want 0", obs_ovf[1]);
    end
  endtask

  task automatic test_ch_en();
    int guard = 0;
    ch_en = 4'b0101;
    repeat (8) tick();
    while (ecount[0] % 4 != 2 && guard < 8) begin
      tick();
      guard++;
    end
    ch_en = 4'b1010;
    repeat (12) begin
      tick();
      n_cmp++;
      if (obs_to[0] !== e_to[0] ||
          !(obs_to[0] === 4'b0000 || obs_to[0] === 4'b0101 || obs_to[0] === 4'b1010)) begin
        n_bad++;
        $display("FAIL ch_en_switch got %b want %b", obs_to[0], e_to[0]);
      end
    end
    ch_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    align_b();
    repeat (3) begin
      sma_trig = 1'b1;
      tick();
      tick();
      sma_trig = 1'b0;
      tick();
      tick();
    end
    while (ecount[1] % 32 != 2) tick();
    n_cmp++;
    if (obs_pend[1] !== 3'd2 || obs_to[1] !== 4'hF) begin
      n_bad++;
      $display("FAIL pre_reset got pend=%0d to=%h want 2 F", obs_pend[1], obs_to[1]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs_to[d] !== 4'h0 || obs_pend[d] !== 3'd0 || obs_ovf[d] !== 1'b0 || obs_mon[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid inst%0d got to=%h pend=%0d ovf=%b mon=%b want 0",
                 d, obs_to[d], obs_pend[d], obs_ovf[d], obs_mon[d]);
      end
    end
    @(posedge osc_clk);
    @(negedge osc_clk);
    rst_n = 1'b1;
    repeat (100) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_to[d] !== e_to[d] || obs_mon[d] !== 1'b0 || obs_pend[d] !== 3'd0) begin
          n_bad++;
          $display("FAIL post_reset inst%0d got to=%h mon=%b pend=%0d want to=%h mon=0 pend=0",
                   d, obs_to[d], obs_mon[d], obs_pend[d], e_to[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    int hi, lo;
    while (cyc < 1500) begin
      hi = $urandom_range(2, 12);
      lo = $urandom_range(2, 40);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) ch_en = 4'($urandom);
      for (int c = 0; c < hi + lo; c++) begin
        sma_trig = (c < hi);
        ovf_clr = ($urandom_range(0, 15) == 0);
        tick();
        cyc++;
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (obs_to[d] !== e_to[d]) begin
            n_bad++;
            $display("FAIL rnd_trig_out inst%0d cyc %0d got %h want %h", d, cyc, obs_to[d], e_to[d]);
          end
          n_cmp++;
          if (obs_mon[d] !== e_mon[d] || obs_stb[d] !== e_stb[d]) begin
            n_bad++;
            $display("FAIL rnd_mon_stb inst%0d cyc %0d got %b%b want %b%b",
                     d, cyc, obs_mon[d], obs_stb[d], e_mon[d], e_stb[d]);
          end
          n_cmp++;
          if (obs_pend[d] !== 3'(pend[d]) || obs_ovf[d] !== ovf[d]) begin
            n_bad++;
            $display("FAIL rnd_queue inst%0d cyc %0d got pend=%0d ovf=%b want pend=%0d ovf=%b",
                     d, cyc, obs_pend[d], obs_ovf[d], pend[d], ovf[d]);
          end
        end
      end
    end
    sma_trig = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_trigger();
    test_mode1();
    test_overflow();
    test_ch_en();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
